// File: rtl/mux2_arb.sv
// mux2_arb: two-channel round-robin arbiter with a registered output slot
// that feeds the gate-level 2:1 mux. sel=1 selects channel 1, sel=0 channel 0.
// Optional feature: define MUX2_ARB_LOCK_EN to add the `lock` input, which
// pins the grant to the channel currently held in q (burst locking).
module mux2_arb #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   output logic             ack0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   output logic             ack1,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             q_ready,
`ifdef MUX2_ARB_LOCK_EN
   input  logic             lock,
`endif
   output logic             sel
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   last_q;
   logic   slot_free;
   logic   grant_vld;
   logic   grant_ch;
   logic   take;

   assign q_valid   = (state_q == FULL);
   assign slot_free = ~q_valid | q_ready;
   assign take      = ack0 | ack1;

   // Grant selection: round-robin on contention, optional lock to current owner
   always_comb begin
      grant_vld = 1'b0;
      grant_ch  = 1'b0;
`ifdef MUX2_ARB_LOCK_EN
      if (lock && q_valid) begin
         grant_ch  = sel;
         grant_vld = sel ? req1 : req0;
      end else
`endif
      if (req0 && req1) begin
         grant_vld = 1'b1;
         grant_ch  = ~last_q;
      end else if (req0) begin
         grant_vld = 1'b1;
         grant_ch  = 1'b0;
      end else if (req1) begin
         grant_vld = 1'b1;
         grant_ch  = 1'b1;
      end
   end

   // Slot occupancy state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: fill on a capture, drain on a consume with no capture
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (take) state_d = FULL;
         FULL:  if (q_ready && !take) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // Handshake outputs; held low while reset is asserted
   always_comb begin
      ack0 = 1'b0;
      ack1 = 1'b0;
      if (rst_n && slot_free && grant_vld) begin
         ack0 = ~grant_ch;
         ack1 = grant_ch;
      end
   end

   // Output word, mux select and round-robin pointer move only on a capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q      <= '0;
         sel    <= 1'b0;
         last_q <= 1'b1;
      end else if (take) begin
         q      <= grant_ch ? a1 : a0;
         sel    <= grant_ch;
         last_q <= grant_ch;
      end
   end

endmodule

// File: doc/mux2_arb.md
# mux2_arb

Two-channel round-robin arbiter and output register that feeds the gate-level 2:1 mux stage. Accepts words from two requesting sources over valid/ack handshakes and picks one per cycle with fair alternation. Presents the chosen word on a registered valid/ready output, together with the registered `sel` that drives the mux's `Sel` input. `sel`=1 selects channel 1 (mux `A1`); `sel`=0 selects channel 0 (mux `A0`).

## Interface
- `WIDTH`, 8: data width of each channel and of `q`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0` input 1: channel 0 has a valid word on `a0`.
- `a0` input WIDTH: channel 0 data.
- `ack0` output 1: channel 0 word accepted this cycle (combinational).
- `req1` input 1: channel 1 has a valid word on `a1`.
- `a1` input WIDTH: channel 1 data.
- `ack1` output 1: channel 1 word accepted this cycle (combinational).
- `q` output WIDTH: registered selected word.
- `q_valid` output 1: `q` holds a word not yet consumed.
- `q_ready` input 1: downstream consumes `q` when `q_valid & q_ready`.
- `sel` output 1: registered channel index of the word in `q`; drives the mux select.
- `lock` input 1: present only with `MUX2_ARB_LOCK_EN` (see Configuration).

## Operation
- Reset is asynchronous and active-low: one clock `clk`, reset `rst_n`.
- Output slot:
  - `slot_free = ~q_valid | q_ready`.
  - The arbiter grants only when `slot_free` = 1.
- Grant rule, evaluated combinationally each cycle:
  - Only one `reqN` high: grant that channel.
  - Both high: grant the channel ≠ `last`.
  - Neither high: no grant.
- `ackN = slot_free & grant==N`. At most one ack is high in any cycle.
- On a rising edge with any ack high:
  - `q` <= granted `aN`.
  - `sel` <= N.
  - `last` <= N.
  - `q_valid` <= 1.
- On a rising edge with `q_valid & q_ready` and no ack: `q_valid` <= 0. `q`, `sel` and `last` hold.
- Simultaneous consume and capture: the new word replaces the old one with no bubble, and `q_valid` stays 1.
- `q_ready` while `q_valid` = 0 has no effect beyond making `slot_free` = 1.
- Internal state: the `q_valid` flag plus the `last` pointer. FSM states:
  - EMPTY (`q_valid`=0): goes to FULL on a grant, else stays.
  - FULL (`q_valid`=1): stays FULL on consume+grant or on stall; goes to EMPTY on consume with no grant.
- A source must hold `reqN`/`aN` stable until it sees `ackN`. A source may drop `reqN` without an ack; the request is then abandoned with no side effect.

## Timing
- Reset values:
  - `q` = 0, `q_valid` = 0, `sel` = 0.
  - `last` = 1, so channel 0 wins the first contention.
  - `ack0` = `ack1` = 0 while `rst_n` = 0.
- Latency: a word accepted (ack) in cycle t appears on `q`/`q_valid`/`sel` after the edge ending cycle t, i.e. in cycle t+1.
- Throughput: one word per cycle while `q_ready` = 1. Under continuous dual requests the channels alternate 0,1,0,1…
- `sel` changes only together with `q`, never mid-word, so the downstream mux sees a stable select for the whole life of each word.
- Reset asserted mid-operation:
  - All registers return to reset values immediately; a pending word in `q` is discarded.
  - Acks go low asynchronously.
  - The first edge after deassertion behaves as after power-up.

## Configuration
- Macro `MUX2_ARB_LOCK_EN`.
- Defined: adds input port `lock`. While `lock` = 1 and `q_valid` = 1, the grant is forced to channel `sel`.
  - If that channel is not requesting, there is no grant, even if the other channel requests.
  - `last` still updates normally.
  - This lets a source keep the mux for back-to-back multi-word bursts.
- Undefined: there is no `lock` port, and arbitration is pure round-robin as above.

## Test plan
- Reset then idle:
  - During reset: `q`=0, `q_valid`=0, `sel`=0, both acks 0.
  - After reset release with no requests: all outputs stay at those values.
- Single channel:
  - Stimulus: `req1`=1, `a1`=0xA5, `q_ready`=1.
  - Required: `ack1`=1 in the same cycle; the next cycle `q`=0xA5, `sel`=1, `q_valid`=1.
- Contention:
  - Stimulus: `req0`=`req1`=1 held for 4 cycles, `a0`=0x11, `a1`=0x22, `q_ready`=1.
  - Required: `q` sequence 0x11, 0x22, 0x11, 0x22 and `sel` sequence 0, 1, 0, 1.
- Backpressure:
  - Stimulus: `q_ready`=0 with `q_valid`=1 and `req0`=1.
  - Required: `ack0`=0 and `q` unchanged for 3 cycles. When `q_ready` rises, `ack0`=1 in that same cycle and the new word is on `q` the next cycle with no bubble.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 while `q_valid`=1, `q`=0x22.
  - Required: `q_valid`=0 and `q`=0 immediately. After release with both requests high, channel 0 is granted first.
- Lock (`MUX2_ARB_LOCK_EN` only):
  - Stimulus: `lock`=1 with `sel`=1, `q_valid`=1, `q_ready`=1, `req0`=`req1`=1 for 3 cycles.
  - Required: only `ack1` pulses, for 3 consecutive words. With `req1`=0 and `lock`=1, no ack is issued.
